// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared constants, types and width helpers for the BedRock IO command arbiter
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_small_cfg   = 2'd1
  } bp_params_e;

  // Largest requester count the arbiter supports, and the id width it needs
  localparam int max_num_req_lp    = 8;
  localparam int max_req_id_w_lp   = $clog2(max_num_req_lp);

  // Requester-id width; never collapses below one bit
  function automatic int req_id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // BedRock mem header width for a processor configuration
  function automatic int bp_mem_header_width(input bp_params_e cfg);
    case (cfg)
      e_bp_small_cfg: return 48;
      default:        return 64;
    endcase
  endfunction

endpackage

// File: rtl/bp_me_io_cmd_arb_rr.sv
// rtl/bp_me_io_cmd_arb_rr.sv - grant select with offer lock; BP_ME_IO_CMD_ARB_RR_EN selects round-robin
module bp_me_io_cmd_arb_rr
  import bp_me_pkg::*;
#(
  parameter  int num_req_p = 2,
  localparam int id_w_lp   = req_id_width(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [num_req_p-1:0] v_i,
  input  logic                 offer_i,
  input  logic                 accept_i,
  output logic [id_w_lp-1:0]   grant_id_o
);

  logic               lock_q, lock_d;
  logic [id_w_lp-1:0] lock_id_q, lock_id_d;
  logic [id_w_lp-1:0] pick;
  logic               handshake;

  assign handshake  = offer_i & accept_i;
  assign grant_id_o = lock_q ? lock_id_q : pick;

`ifdef BP_ME_IO_CMD_ARB_RR_EN
  logic [id_w_lp-1:0] ptr_q, ptr_d;

  // Rotating search: first valid requester at or after the pointer
  always_comb begin : p_pick
    int                 tmp;
    logic [id_w_lp-1:0] idx;
    logic               found;
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      tmp = int'(ptr_q) + i;
      if (tmp >= num_req_p) tmp = tmp - num_req_p;
      idx = id_w_lp'(tmp);
      if (!found && v_i[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Pointer moves just past the requester that completed a handshake
  always_comb begin
    ptr_d = ptr_q;
    if (handshake) begin
      ptr_d = (grant_id_o == id_w_lp'(num_req_p - 1)) ? '0 : grant_id_o + id_w_lp'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest-index valid requester wins
  always_comb begin : p_pick
    logic [id_w_lp-1:0] idx;
    pick = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      idx = id_w_lp'(i);
      if (v_i[idx]) pick = idx;
    end
  end
`endif

  // An offer left hanging pins the grant until it is taken downstream
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (handshake) begin
      lock_d = 1'b0;
    end else if (offer_i) begin
      lock_d    = 1'b1;
      lock_id_d = grant_id_o;
    end
  end

  // Lock flag and locked id registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small one-read one-write FIFO with valid/ready push and yumi pop
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                push;
  logic                pop;

  // A full FIFO refuses pushes even when a pop happens the same cycle
  assign ready_o = (count_q != cnt_w_lp'(els_p));
  assign v_o     = (count_q != '0);
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;
  assign data_o  = mem_q[rptr_q];

  // Pointer wrap and occupancy bookkeeping
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = (wptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wptr_q + ptr_w_lp'(1);
    if (pop)  rptr_d = (rptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rptr_q + ptr_w_lp'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

  // Control state, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bp_me_io_cmd_arbiter.sv
// rtl/bp_me_io_cmd_arbiter.sv - N-to-1 IO command arbiter with in-order response return; BP_ME_IO_CMD_ARB_RR_EN enables round-robin
module bp_me_io_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter  bp_params_e bp_params_p       = e_bp_default_cfg,
  parameter  int         num_req_p         = 2,
  parameter  int         io_data_width_p   = 64,
  parameter  int         num_outstanding_p = 8,
  localparam int         mem_header_width_lp = bp_mem_header_width(bp_params_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_req_p*mem_header_width_lp-1:0] cmd_header_i,
  input  logic [num_req_p*io_data_width_p-1:0]   cmd_data_i,
  input  logic [num_req_p-1:0]                   cmd_v_i,
  output logic [num_req_p-1:0]                   cmd_ready_and_o,
  output logic [mem_header_width_lp-1:0]         resp_header_o,
  output logic [io_data_width_p-1:0]             resp_data_o,
  output logic [num_req_p-1:0]                   resp_v_o,
  input  logic [num_req_p-1:0]                   resp_ready_and_i,
  output logic [mem_header_width_lp-1:0]         io_cmd_header_o,
  output logic [io_data_width_p-1:0]             io_cmd_data_o,
  output logic                                   io_cmd_v_o,
  input  logic                                   io_cmd_ready_and_i,
  input  logic [mem_header_width_lp-1:0]         io_resp_header_i,
  input  logic [io_data_width_p-1:0]             io_resp_data_i,
  input  logic                                   io_resp_v_i,
  output logic                                   io_resp_ready_and_o
);

  localparam int hdr_w_lp = mem_header_width_lp;
  localparam int id_w_lp  = req_id_width(num_req_p);

  logic [id_w_lp-1:0] grant_id;
  logic [id_w_lp-1:0] head_id;
  logic               fifo_ready;
  logic               fifo_v;
  logic               full;
  logic               empty;
  logic               cmd_fire;
  logic               resp_fire;

  assign full  = ~fifo_ready;
  assign empty = ~fifo_v;

  // Command path: granted slice straight through; reset forces the offer low
  assign io_cmd_v_o      = reset_n_i & (|cmd_v_i) & ~full;
  assign io_cmd_header_o = cmd_header_i[grant_id*hdr_w_lp +: hdr_w_lp];
  assign io_cmd_data_o   = cmd_data_i[grant_id*io_data_width_p +: io_data_width_p];
  assign cmd_fire        = io_cmd_v_o & io_cmd_ready_and_i;

  // Only the granted requester sees the downstream ready
  always_comb begin
    cmd_ready_and_o           = '0;
    cmd_ready_and_o[grant_id] = reset_n_i & io_cmd_ready_and_i & ~full;
  end

  // Response path: payload is broadcast, valid steered to the oldest requester
  assign resp_header_o       = io_resp_header_i;
  assign resp_data_o         = io_resp_data_i;
  assign io_resp_ready_and_o = resp_ready_and_i[head_id] & ~empty;
  assign resp_fire           = io_resp_v_i & io_resp_ready_and_o;

  // Valid steering to the requester at the head of the order FIFO
  always_comb begin
    resp_v_o          = '0;
    resp_v_o[head_id] = io_resp_v_i & ~empty;
  end

  bp_me_io_cmd_arb_rr #(
    .num_req_p(num_req_p)
  ) u_arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (cmd_v_i),
    .offer_i   (io_cmd_v_o),
    .accept_i  (io_cmd_ready_and_i),
    .grant_id_o(grant_id)
  );

  // Remembers who issued each in-flight command so responses return in order
  bsg_fifo_1r1w_small #(
    .width_p(id_w_lp),
    .els_p  (num_outstanding_p)
  ) u_order_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (cmd_fire),
    .ready_o  (fifo_ready),
    .data_i   (grant_id),
    .v_o      (fifo_v),
    .data_o   (head_id),
    .yumi_i   (resp_fire)
  );

  // A response with nothing outstanding has no requester to go to
  a_no_unmatched_resp: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(io_resp_v_i && empty));

endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
// tb/tb_bp_me_io_cmd_arbiter.sv - directed self-checking bench for bp_me_io_cmd_arbiter
module tb_bp_me_io_cmd_arbiter;
  import bp_me_pkg::*;

  localparam int n_lp  = 2;
  localparam int hw_lp = 64;
  localparam int dw_lp = 64;
`ifdef BP_ME_IO_CMD_ARB_RR_EN
  localparam bit rr_lp = 1'b1;
`else
  localparam bit rr_lp = 1'b0;
`endif

  localparam logic [hw_lp-1:0] hdr0 = 64'hA0A0_0000_0000_1000;
  localparam logic [hw_lp-1:0] hdr1 = 64'hB1B1_0000_0000_2001;
  localparam logic [dw_lp-1:0] dat0 = 64'hD000_0000_CAFE_0000;
  localparam logic [dw_lp-1:0] dat1 = 64'hD111_1111_BEEF_0001;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [n_lp*hw_lp-1:0]  cmd_header;
  logic [n_lp*dw_lp-1:0]  cmd_data;
  logic [n_lp-1:0]        cmd_v;
  logic [n_lp-1:0]        cmd_ready;
  logic [hw_lp-1:0]       resp_header;
  logic [dw_lp-1:0]       resp_data;
  logic [n_lp-1:0]        resp_v;
  logic [n_lp-1:0]        resp_ready;
  logic [hw_lp-1:0]       io_cmd_header;
  logic [dw_lp-1:0]       io_cmd_data;
  logic                   io_cmd_v;
  logic                   io_cmd_ready;
  logic [hw_lp-1:0]       io_resp_header;
  logic [dw_lp-1:0]       io_resp_data;
  logic                   io_resp_v;
  logic                   io_resp_ready;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int eg;
  int eh;
  int exp_q[$];

  always #5 clk = ~clk;

  bp_me_io_cmd_arbiter #(
    .bp_params_p      (e_bp_default_cfg),
    .num_req_p        (n_lp),
    .io_data_width_p  (dw_lp),
    .num_outstanding_p(8)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (rst_n),
    .cmd_header_i       (cmd_header),
    .cmd_data_i         (cmd_data),
    .cmd_v_i            (cmd_v),
    .cmd_ready_and_o    (cmd_ready),
    .resp_header_o      (resp_header),
    .resp_data_o        (resp_data),
    .resp_v_o           (resp_v),
    .resp_ready_and_i   (resp_ready),
    .io_cmd_header_o    (io_cmd_header),
    .io_cmd_data_o      (io_cmd_data),
    .io_cmd_v_o         (io_cmd_v),
    .io_cmd_ready_and_i (io_cmd_ready),
    .io_resp_header_i   (io_resp_header),
    .io_resp_data_i     (io_resp_data),
    .io_resp_v_i        (io_resp_v),
    .io_resp_ready_and_o(io_resp_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cmd_header     = {hdr1, hdr0};
    cmd_data       = {dat1, dat0};
    rst_n          = 1'b0;
    cmd_v          = 2'b11;
    io_cmd_ready   = 1'b1;
    resp_ready     = 2'b11;
    io_resp_v      = 1'b0;
    io_resp_header = 64'h5A5A_0000_1234_5678;
    io_resp_data   = 64'h0F0F_F0F0_0000_0042;

    // Reset holds every handshake output low even with requests pending
    #2;
    chk("rst_io_cmd_v", io_cmd_v, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_resp_v", resp_v, 0);
    chk("rst_io_resp_ready", io_resp_ready, 0);
    cmd_v = 2'b00;
    cyc();
    cyc();
    rst_n = 1'b1;

    // Both requesters sustained with downstream always ready
    cmd_v = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      eg = rr_lp ? (i % 2) : 0;
      chk("burst_io_cmd_v", io_cmd_v, 1);
      chk("burst_cmd_ready", cmd_ready, 2'b01 << eg);
      chk("burst_hdr", io_cmd_header, eg ? hdr1 : hdr0);
      chk("burst_data", io_cmd_data, eg ? dat1 : dat0);
      exp_q.push_back(eg);
      cyc();
    end
    cmd_v = 2'b00;

    // Responses come back to the same requesters in issue order
    io_resp_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      eh = exp_q.pop_front();
      chk("drain_resp_v", resp_v, 2'b01 << eh);
      chk("drain_resp_ready", io_resp_ready, 1);
      cyc();
    end
    io_resp_v = 1'b0;
    #1;
    chk("drain_empty", io_resp_ready, 0);
    chk("resp_hdr_pass", resp_header, io_resp_header);
    chk("resp_data_pass", resp_data, io_resp_data);

    // Requester 1 offers into a stalled downstream; requester 0 must not steal it
    cmd_v        = 2'b10;
    io_cmd_ready = 1'b0;
    #1;
    chk("lock_first_v", io_cmd_v, 1);
    chk("lock_first_hdr", io_cmd_header, hdr1);
    cyc();
    cmd_v = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lock_hold_hdr", io_cmd_header, hdr1);
      chk("lock_hold_ready", cmd_ready, 2'b00);
      cyc();
    end
    io_cmd_ready = 1'b1;
    #1;
    chk("lock_release_ready", cmd_ready, 2'b10);
    chk("lock_release_data", io_cmd_data, dat1);
    cyc();
    cmd_v     = 2'b00;
    io_resp_v = 1'b1;
    #1;
    chk("lock_resp_v", resp_v, 2'b10);
    cyc();
    io_resp_v = 1'b0;

    // Issue order 0,1,1 then return with a stall on requester 1
    cmd_v = 2'b01;
    #1;
    chk("ord_cmd0", cmd_ready, 2'b01);
    cyc();
    cmd_v = 2'b10;
    #1;
    chk("ord_cmd1a", cmd_ready, 2'b10);
    cyc();
    #1;
    chk("ord_cmd1b", cmd_ready, 2'b10);
    cyc();
    cmd_v          = 2'b00;
    io_resp_v      = 1'b1;
    io_resp_header = 64'h0000_7777_0000_0003;
    #1;
    chk("ord_resp_v0", resp_v, 2'b01);
    chk("ord_ready0", io_resp_ready, 1);
    chk("ord_hdr_pass", resp_header, 64'h0000_7777_0000_0003);
    cyc();
    resp_ready = 2'b01;
    #1;
    chk("ord_resp_v1_stall", resp_v, 2'b10);
    chk("ord_ready1_stall", io_resp_ready, 0);
    cyc();
    resp_ready = 2'b11;
    #1;
    chk("ord_resp_v1a", resp_v, 2'b10);
    chk("ord_ready1a", io_resp_ready, 1);
    cyc();
    #1;
    chk("ord_resp_v1b", resp_v, 2'b10);
    cyc();
    io_resp_v = 1'b0;
    #1;
    chk("ord_empty", io_resp_ready, 0);

    // Eight commands with no responses fill the order FIFO
    cmd_v = 2'b01;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fill_cmd_ready", cmd_ready, 2'b01);
      cyc();
    end
    #1;
    chk("full_cmd_ready", cmd_ready, 2'b00);
    chk("full_io_cmd_v", io_cmd_v, 0);
    cyc();
    #1;
    chk("full_hold", cmd_ready, 2'b00);

    // Push and pop together while full: pop taken, push refused
    io_resp_v = 1'b1;
    #1;
    chk("pp_cmd_ready", cmd_ready, 2'b00);
    chk("pp_resp_ready", io_resp_ready, 1);
    chk("pp_resp_v", resp_v, 2'b01);
    cyc();
    io_resp_v = 1'b0;
    #1;
    chk("pp_room_for_one", cmd_ready, 2'b01);
    cyc();
    #1;
    chk("pp_full_again", cmd_ready, 2'b00);

    // Reset mid-burst clears everything asynchronously
    cmd_v     = 2'b11;
    io_resp_v = 1'b1;
    #1;
    chk("pre_rst_resp_v", resp_v, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_io_cmd_v", io_cmd_v, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 2'b00);
    chk("mid_rst_resp_v", resp_v, 2'b00);
    chk("mid_rst_resp_ready", io_resp_ready, 0);
    io_resp_v = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", cmd_ready, 2'b01);
    chk("post_rst_empty", io_resp_ready, 0);
    cyc();
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("post_rst_fill", |cmd_ready, 1);
      cyc();
    end
    #1;
    chk("post_rst_full", cmd_ready, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bp_me_io_cmd_arbiter.md
BP_ME_IO_CMD_ARBITER -- requirements
Module: bp_me_io_cmd_arbiter

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg: processor configuration; derives mem_header_width_lp (hdr_w).
REQ-002 SHALL have parameter num_req_p, default 2: number of BedRock mem requesters, legal range 2..8.
REQ-003 SHALL have parameter io_data_width_p, default 64: command/response data width.
REQ-004 SHALL have parameter num_outstanding_p, default 8: maximum in-flight commands; this is the order FIFO depth.
REQ-005 SHALL have clk_i  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have reset_n_i  in  1  asynchronous, active-low reset.
REQ-007 SHALL have cmd_header_i  in  num_req_p*hdr_w  packed requester headers, requester i at slice i.
REQ-008 SHALL have cmd_data_i  in  num_req_p*io_data_width_p  packed requester data.
REQ-009 SHALL have cmd_v_i  in  num_req_p / cmd_ready_and_o  out  num_req_p  per-requester command handshake.
REQ-010 SHALL have resp_header_o  out  hdr_w / resp_data_o  out  io_data_width_p  response payload, broadcast to all requesters.
REQ-011 SHALL have resp_v_o  out  num_req_p / resp_ready_and_i  in  num_req_p  per-requester response handshake.
REQ-012 SHALL have io_cmd_header_o  out  hdr_w, io_cmd_data_o  out  io_data_width_p, io_cmd_v_o  out  1, io_cmd_ready_and_i  in  1  downstream command port to the shared AXI-lite master.
REQ-013 SHALL have io_resp_header_i  in  hdr_w, io_resp_data_i  in  io_data_width_p, io_resp_v_i  in  1, io_resp_ready_and_o  out  1  downstream response port.

Function
REQ-014 SHALL forward exactly one requester per cycle: io_cmd_* = slice of granted index g; io_cmd_v_o = |cmd_v_i & !full.
REQ-015 SHALL assert cmd_ready_and_o[g] = io_cmd_ready_and_i & !full; all other bits 0.
REQ-016 SHALL lock g once io_cmd_v_o=1 without io_cmd_ready_and_i, holding it until the downstream handshake (no grant switching mid-offer).
REQ-017 SHALL on each downstream command handshake push g into the order FIFO and advance the priority pointer to (g+1) mod num_req_p.
REQ-018 SHALL treat full (num_outstanding_p entries) as blocking: no push even if a pop occurs the same cycle.
REQ-019 SHALL route responses in order: resp_v_o[h] = io_resp_v_i & !empty, where h = FIFO head; io_resp_ready_and_o = resp_ready_and_i[h] & !empty.
REQ-020 SHALL pop the FIFO on response handshake; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-021 SHALL hold io_resp_ready_and_o=0 when empty; io_resp_v_i while empty SHALL fire a simulation assertion.
REQ-022 SHALL pass headers and data through unmodified; zero added latency on both paths.

Reset
REQ-023 SHALL, on reset_n_i low, asynchronously clear the FIFO, lock flag and pointer (0); io_cmd_v_o, all cmd_ready_and_o and resp_v_o = 0.
REQ-024 SHALL discard in-flight state on reset mid-operation; responses arriving after reset are unmatched (REQ-021).

Configuration
REQ-025 SHALL, with BP_ME_IO_CMD_ARB_RR_EN defined, select round-robin from the pointer of REQ-017.
REQ-026 SHALL, without BP_ME_IO_CMD_ARB_RR_EN, use fixed priority (lowest valid index wins); pointer logic removed.

Structure
REQ-027 SHALL place requester-id width (clog2 num_req_p) and max num_req_p constant in bp_me_pkg.
REQ-028 SHALL instantiate bsg_fifo_1r1w_small for the order FIFO and one sub-module bp_me_io_cmd_arb_rr (pointer + grant/lock).

Verification
REQ-029 SHALL cover: cmd_v_i=2'b11 sustained, ready=1, RR -> grants 0,1,0,1; fixed -> 0,0,0,0.
REQ-030 SHALL cover: requester 1 offers, io_cmd_ready_and_i low 3 cycles, requester 0 asserts -> g stays 1 until handshake.
REQ-031 SHALL cover: 8 commands without responses -> 9th blocked (cmd_ready_and_o=0) until one response pops.
REQ-032 SHALL cover: order 0,1,1 issued, responses returned -> resp_v_o sequence 01,10,10; resp_ready_and_i[1]=0 stalls io_resp_ready_and_o.
REQ-033 SHALL cover: full FIFO with push and pop same cycle -> push refused, occupancy 7.
REQ-034 SHALL cover: reset_n_i low mid-burst -> all outputs 0 asynchronously, FIFO empty, pointer 0.
